baggage_drop_ctrl: RTL and testbench
====================================

// Module: baggage_drop_ctrl
// PURPOSE
// Sequences one baggage-drop cycle around the display/drop-decision datapath. Accepts a bag request,
// averages SAMPLES sensor readings into t_act (8.8 fixed point), waits out the cooldown window, then
// raises drop_en so the decision logic compares t_act with t_lim. If that logic returns drop_activated,
// the block pulses the gate actuator for GATE_CYCLES. It sits between sensor/operator I/O and the decision block.
// PARAMETERS
// SAMPLES      4     sensor samples averaged per bag; power of two, 2..16
// COOL_CYCLES  1000  clk cycles drop_en is held low after averaging ("COLD" shown)
// GATE_CYCLES  500   clk cycles gate_open is held high on a drop
// PORTS
// clk             in   1   system clock, rising edge
// rst_n           in   1   asynchronous active-low reset
// bag_req         in   1   bag present; held high until bag_ack
// bag_ack         out  1   one-cycle pulse when the cycle completes (DONE)
// sens_valid      in   1   sens_data valid this cycle
// sens_data       in   16  height sample, 8.8 fixed point
// t_act           out  16  averaged height to decision block; registered
// drop_en         out  1   enable to decision block
// drop_activated  in   1   decision result, combinational from t_act/t_lim/drop_en
// gate_open       out  1   actuator drive
// busy            out  1   high in every state except IDLE
// BEHAVIOUR
// Reset: all outputs 0; t_act=16'h0000; FSM=IDLE; accumulator and counters 0. Reset is valid in any state
//   and aborts the cycle with no bag_ack. gate_open must drop the same cycle rst_n falls.
// FSM: IDLE -> SAMPLE -> COOL -> DECIDE -> (GATE | DONE); GATE -> DONE; DONE -> IDLE.
// IDLE: a sampled bag_req=1 -> SAMPLE; clear accumulator and sample counter.
// SAMPLE: each cycle with sens_valid=1 adds sens_data to a 20-bit accumulator (16+log2(16), no overflow).
//   Samples without sens_valid are ignored; no timeout. After SAMPLES valid samples, t_act <= acc>>log2(SAMPLES)
//   (truncating), registered the cycle after the last sample; -> COOL.
// COOL: drop_en=0 for exactly COOL_CYCLES cycles; -> DECIDE.
// DECIDE: drop_en=1. Hold one cycle so the result settles, then sample drop_activated on the second cycle:
//   1 -> GATE, 0 -> DONE. drop_en stays 1 through GATE and DONE.
// GATE: gate_open=1 for exactly GATE_CYCLES cycles; -> DONE.
// DONE: bag_ack=1 for one cycle; drop_en<=0 and t_act held on exit; -> IDLE.
// A new request is accepted only after the requester drops bag_req: IDLE ignores a bag_req level that has
//   stayed high since the ack. Use a req_armed flag, set when bag_req=0 is seen in IDLE and cleared on accept.
// bag_req falling mid-cycle has no effect; the cycle runs to DONE.
// t_act keeps its last value between bags and changes only at the end of SAMPLE.
// busy = (state != IDLE), decoded from registered state.
// Timer counts down from N-1 to 0; N=1 gives a single-cycle state.
// STRUCTURE
// Package baggage_pkg: FSM state encoding (3-bit localparams IDLE..DONE), FIX_W=16 (8.8 width), ACC_W=20.
// Sub-module bd_timer: loadable down-counter (load, value, expired). It is shared by COOL and GATE and
//   reloaded on each state entry.
// Top level holds the FSM, the accumulator and sample counter, the req_armed flag and the output registers.
// TESTING
// 1 Reset mid-GATE: assert rst_n=0 -> gate_open, drop_en, busy go 0 at once; no bag_ack; IDLE after release.
// 2 SAMPLES=4, data 0x0A00,0x0A80,0x0B00,0x0B80, t_lim=0x0C00 -> t_act=0x0AC0; drop_en after 1000 cycles;
//   gate_open high for exactly 500 cycles; bag_ack pulses once.
// 3 Data all 0x0D40, t_lim=0x0C00 -> t_act=0x0D40; no gate_open; bag_ack 2 cycles after drop_en rises.
// 4 sens_valid gaps (valid on 4 of 10 cycles, others carry 0xFFFF) -> only valid samples counted;
//   t_act equals the mean of the valid samples.
// 5 bag_req held high after bag_ack -> no second cycle until bag_req goes low for >=1 cycle and high again.
// 6 Boundary: all samples 0xFFFF -> t_act=0xFFFF (no overflow); t_act==t_lim -> no drop.

Source files
------------

// File: rtl/baggage_drop_ctrl_pkg.sv
// Shared definitions for the baggage-drop sequencer: state encoding, fixed-point
// widths and the truncating average helper.
package baggage_pkg;

  localparam int FIX_W = 16;
  localparam int ACC_W = 20;
  // One bit wider than log2(16) so the count can reach SAMPLES itself.
  localparam int CNT_W = ACC_W - FIX_W + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_COOL   = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_GATE   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SAMPLE = ST_SAMPLE,
    S_COOL   = ST_COOL,
    S_DECIDE = ST_DECIDE,
    S_GATE   = ST_GATE,
    S_DONE   = ST_DONE
  } state_e;

  function automatic logic [FIX_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc,
                                                 input int unsigned shift);
    logic [ACC_W-1:0] q;
    q = acc >> shift;
    return q[FIX_W-1:0];
  endfunction

endpackage

// File: rtl/baggage_drop_ctrl_timer.sv
// Loadable down-counter shared by the cooldown and gate windows; expired is high
// while the count sits at zero.
module bd_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/baggage_drop_ctrl.sv
// Sequences one bag: average SAMPLES sensor readings, cool down, let the decision
// block judge t_act, pulse the gate if it says drop, then acknowledge the request.
module baggage_drop_ctrl
  import baggage_pkg::*;
#(
  parameter int unsigned SAMPLES     = 4,
  parameter int unsigned COOL_CYCLES = 1000,
  parameter int unsigned GATE_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bag_req,
  output logic             bag_ack,
  input  logic             sens_valid,
  input  logic [FIX_W-1:0] sens_data,
  output logic [FIX_W-1:0] t_act,
  output logic             drop_en,
  input  logic             drop_activated,
  output logic             gate_open,
  output logic             busy
);

  localparam int unsigned SHIFT = $clog2(SAMPLES);
  localparam int unsigned MAX_CYC = (COOL_CYCLES > GATE_CYCLES) ? COOL_CYCLES : GATE_CYCLES;
  localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] COOL_LD  = TMR_W'(COOL_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD  = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLES - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FIX_W-1:0] t_act_q, t_act_d;
  logic             armed_q, armed_d;
  logic             settle_q, settle_d;
  logic             drop_en_q, drop_en_d;
  logic             gate_q, gate_d;
  logic             ack_q, ack_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;
  logic [ACC_W-1:0] sum;

  bd_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    t_act_d   = t_act_q;
    armed_d   = armed_q;
    settle_d  = settle_q;
    drop_en_d = drop_en_q;
    gate_d    = gate_q;
    ack_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = COOL_LD;
    sum       = acc_q + {{(ACC_W-FIX_W){1'b0}}, sens_data};

    case (state_q)
      S_IDLE: begin
        // A level left high since the last ack must fall before it can start a new bag.
        if (!bag_req) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (sens_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SMP) begin
            t_act_d  = avg_trunc(sum, SHIFT);
            tmr_load = 1'b1;
            tmr_val  = COOL_LD;
            state_d  = S_COOL;
          end
        end
      end
      S_COOL: begin
        if (tmr_exp) begin
          drop_en_d = 1'b1;
          settle_d  = 1'b0;
          state_d   = S_DECIDE;
        end
      end
      S_DECIDE: begin
        // First cycle lets the comparator settle on the new enable; decide on the second.
        if (!settle_q) begin
          settle_d = 1'b1;
        end else if (drop_activated) begin
          gate_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GATE_LD;
          state_d  = S_GATE;
        end else begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_GATE: begin
        if (tmr_exp) begin
          gate_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        drop_en_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        drop_en_d = 1'b0;
        gate_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      t_act_q   <= '0;
      armed_q   <= 1'b0;
      settle_q  <= 1'b0;
      drop_en_q <= 1'b0;
      gate_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      t_act_q   <= t_act_d;
      armed_q   <= armed_d;
      settle_q  <= settle_d;
      drop_en_q <= drop_en_d;
      gate_q    <= gate_d;
      ack_q     <= ack_d;
    end
  end

  assign t_act     = t_act_q;
  assign drop_en   = drop_en_q;
  assign gate_open = gate_q;
  assign bag_ack   = ack_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Randomized bench for baggage_drop_ctrl with a queue-based scoreboard and a
// behavioural model of the downstream decision block.
module tb_baggage_drop_ctrl;

  localparam int SAMPLES = 4;
  localparam int COOL    = 1000;
  localparam int GATE    = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bag_req = 1'b0;
  logic        sens_valid = 1'b0;
  logic [15:0] sens_data = 16'h0;
  logic [15:0] t_lim = 16'h0C00;
  logic        bag_ack, drop_en, gate_open, busy, drop_activated;
  logic [15:0] t_act;

  // Decision block: drop when the measured height is strictly under the limit.
  assign drop_activated = drop_en && (t_act < t_lim);

  baggage_drop_ctrl #(
    .SAMPLES     (SAMPLES),
    .COOL_CYCLES (COOL),
    .GATE_CYCLES (GATE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bag_req        (bag_req),
    .bag_ack        (bag_ack),
    .sens_valid     (sens_valid),
    .sens_data      (sens_data),
    .t_act          (t_act),
    .drop_en        (drop_en),
    .drop_activated (drop_activated),
    .gate_open      (gate_open),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t_act;
    bit gate;
    int last_cap;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] smp[16];
  int gap[16];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures each bag as the DUT presents it and checks it on bag_ack.
  initial begin
    int   drop_rise;
    int   gate_cnt;
    bit   prev_drop;
    exp_t e;
    drop_rise = 0;
    gate_cnt  = 0;
    prev_drop = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        drop_rise = 0;
        gate_cnt  = 0;
        prev_drop = 1'b0;
        chk("ack_in_reset", bag_ack, 0);
      end else begin
        if (drop_en && !prev_drop) drop_rise = cyc;
        prev_drop = drop_en;
        if (gate_open) gate_cnt++;
        if (bag_ack) begin
          if (exp_q.size() == 0) begin
            chk("spurious_ack", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("t_act", t_act, e.t_act);
            chk("gate_cycles", gate_cnt, e.gate ? GATE : 0);
            chk("cool_len", drop_rise - e.last_cap, COOL);
            chk("ack_delay", cyc - drop_rise, e.gate ? 2 + GATE : 2);
          end
          gate_cnt = 0;
        end
      end
    end
  end

  task automatic do_bag(input int hold_after, input bit rst_mid_gate);
    int   sum;
    bit   ok;
    exp_t e;
    sum = 0;
    for (int i = 0; i < SAMPLES; i++) sum += int'(smp[i]);
    e.t_act    = sum / SAMPLES;
    e.gate     = (e.t_act < int'(t_lim));
    e.last_cap = 0;
    bag_req = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", ok, 1);
    if (!ok) begin
      bag_req = 1'b0;
      return;
    end
    for (int i = 0; i < SAMPLES; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        sens_valid = 1'b0;
        sens_data  = (g % 2 == 0) ? 16'hFFFF : 16'($urandom);
        tick();
      end
      sens_valid = 1'b1;
      sens_data  = smp[i];
      e.last_cap = cyc + 1;
      tick();
    end
    sens_valid = 1'b0;
    sens_data  = 16'($urandom);
    exp_q.push_back(e);

    if (rst_mid_gate) begin
      ok = 1'b0;
      for (int k = 0; k < COOL + 20; k++) begin
        tick();
        if (gate_open) begin
          ok = 1'b1;
          break;
        end
      end
      chk("gate_seen", ok, 1);
      repeat (50) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_gate_open", gate_open, 0);
      chk("rst_drop_en", drop_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_t_act", t_act, 0);
      exp_q.delete();
      bag_req = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) begin
        tick();
        chk("idle_after_rst", busy, 0);
      end
      return;
    end

    ok = 1'b0;
    for (int k = 0; k < COOL + GATE + 200; k++) begin
      tick();
      if (bag_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_seen", ok, 1);
    if (hold_after > 0) begin
      tick();
      for (int k = 0; k < hold_after; k++) begin
        tick();
        chk("no_rearm", busy, 0);
      end
    end
    bag_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic fill(input logic [15:0] v, input int gp);
    for (int i = 0; i < 16; i++) begin
      smp[i] = v;
      gap[i] = gp;
    end
  endtask

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int m;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_t_act", t_act, 0);
    chk("reset_bag_ack", bag_ack, 0);
    chk("reset_drop_en", drop_en, 0);
    chk("reset_gate_open", gate_open, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    tick();

    fill(16'h0, 0);
    smp[0] = 16'h0A00;
    smp[1] = 16'h0A80;
    smp[2] = 16'h0B00;
    smp[3] = 16'h0B80;
    t_lim = 16'h0C00;
    do_bag(0, 1'b0);

    fill(16'h0D40, 0);
    do_bag(0, 1'b0);

    fill(16'h0, 0);
    smp[0] = 16'h1234; smp[1] = 16'h0F00; smp[2] = 16'h0001; smp[3] = 16'h2222;
    gap[0] = 2; gap[1] = 1; gap[2] = 0; gap[3] = 3;
    t_lim = 16'h2000;
    do_bag(0, 1'b0);

    fill(16'h0800, 1);
    t_lim = 16'h0C00;
    do_bag(5, 1'b0);

    fill(16'hFFFF, 0);
    t_lim = 16'hFFFF;
    do_bag(0, 1'b0);

    fill(16'h0B00, 0);
    smp[0] = 16'h0B03;
    t_lim = 16'h0B00;
    do_bag(0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      m = 0;
      for (int i = 0; i < SAMPLES; i++) begin
        smp[i] = 16'($urandom);
        gap[i] = int'($urandom_range(0, 3));
        m += int'(smp[i]);
      end
      m = m / SAMPLES;
      case (r % 3)
        0: t_lim = 16'(m);
        1: t_lim = (m == 16'hFFFF) ? 16'hFFFF : 16'(m + 1);
        default: t_lim = 16'($urandom);
      endcase
      do_bag(int'($urandom_range(0, 2)), 1'b0);
    end

    fill(16'h0400, 1);
    t_lim = 16'hF000;
    do_bag(0, 1'b1);

    fill(16'h0300, 0);
    smp[3] = 16'h0304;
    t_lim = 16'h0C00;
    do_bag(0, 1'b0);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
